// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchroniser, mid-bit sampling FSM and a
// valid/ready holding register with one-cycle framing-error and overrun pulses.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5001,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic               s1_q, rx_s_q;

    // Synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q   <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            s1_q   <= rx;
            rx_s_q <= s1_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_WAIT_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Consumption; a delivery in the same cycle overrides it below.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            ST_WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                        if (!valid_q || ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        state_d     = ST_WAIT_IDLE;
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_WAIT_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: table of back-to-back frames
// plus hand sequences for glitch, framing error, overrun and mid-frame reset.
module tb_uart_rx;

    localparam int unsigned CPB    = 16;
    localparam int unsigned HB     = CPB / 2;
    localparam int          LAT_LO = 2 + HB + 9 * CPB + 1;
    localparam int          LAT_HI = 2 + HB + 9 * CPB + 3;
    localparam int          NVEC   = 14;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       rdy;
        int         exp_acc;
        logic [7:0] exp_data;
        int         exp_fe;
        int         exp_ov;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    int         n_acc = 0, n_vhi = 0, n_vrise = 0, n_fe = 0, n_ov = 0;
    int         t_vrise = 0, t_fe = 0;
    logic [7:0] last_acc = 8'h00;
    logic       prev_valid = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Event monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (valid) n_vhi++;
        if (valid && !prev_valid) begin
            n_vrise++;
            t_vrise = cyc;
        end
        if (valid && ready) begin
            n_acc++;
            last_acc = data;
        end
        if (frame_err) begin
            n_fe++;
            t_fe = cyc;
        end
        if (overrun) n_ov++;
        prev_valid = valid;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic expect_byte(input string name, input logic [7:0] d);
        int b_acc, b_fe, b_ov, t0;
        b_acc = n_acc; b_fe = n_fe; b_ov = n_ov;
        ready = 1'b1;
        t0 = cyc;
        send_frame(d, 1'b1);
        check({name, " accepts"}, n_acc - b_acc, 1);
        check({name, " data"}, int'(last_acc), int'(d));
        check({name, " errors"}, (n_fe - b_fe) + (n_ov - b_ov), 0);
        check({name, " latency ok"}, int'((t_vrise - t0) >= LAT_LO && (t_vrise - t0) <= LAT_HI), 1);
    endtask

    vec_t       vt [NVEC];
    logic [7:0] msg [13];

    initial begin
        int b_acc, b_vhi, b_vrise, b_fe, b_ov, t0, lat;
        logic ok;

        msg = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77,
                8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
        vt[0] = '{d: 8'h68, stop: 1'b1, rdy: 1'b1, exp_acc: 1, exp_data: 8'h68, exp_fe: 0, exp_ov: 0};
        for (int k = 0; k < 13; k++) begin
            vt[k+1] = '{d: msg[k], stop: 1'b1, rdy: 1'b1, exp_acc: 1, exp_data: msg[k], exp_fe: 0, exp_ov: 0};
        end

        reset = 1'b0;
        rx    = 1'b1;
        ready = 1'b0;
        repeat (3) tick();
        check("reset data", int'(data), 0);
        check("reset valid", int'(valid), 0);
        check("reset frame_err", int'(frame_err), 0);
        check("reset overrun", int'(overrun), 0);
        reset = 1'b1;
        repeat (CPB) tick();

        // Single byte followed by the back-to-back stream.
        for (int i = 0; i < NVEC; i++) begin
            b_acc = n_acc; b_vhi = n_vhi; b_fe = n_fe; b_ov = n_ov;
            ready = vt[i].rdy;
            t0 = cyc;
            send_frame(vt[i].d, vt[i].stop);
            lat = t_vrise - t0;
            ok = ((n_acc - b_acc) == vt[i].exp_acc) && ((n_vhi - b_vhi) == vt[i].exp_acc)
                 && ((n_fe - b_fe) == vt[i].exp_fe) && ((n_ov - b_ov) == vt[i].exp_ov)
                 && (vt[i].exp_acc == 0 || (last_acc == vt[i].exp_data && lat >= LAT_LO && lat <= LAT_HI));
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL vec%0d: acc=%0d vhi=%0d data=%02h fe=%0d ov=%0d lat=%0d, expected acc=%0d vhi=%0d data=%02h fe=%0d ov=%0d lat=%0d..%0d",
                         i, n_acc - b_acc, n_vhi - b_vhi, last_acc, n_fe - b_fe, n_ov - b_ov, lat,
                         vt[i].exp_acc, vt[i].exp_acc, vt[i].exp_data, vt[i].exp_fe, vt[i].exp_ov, LAT_LO, LAT_HI);
            end
        end
        repeat (CPB) tick();

        // Short low glitch must be rejected.
        b_vrise = n_vrise; b_fe = n_fe; b_ov = n_ov;
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (2 * CPB) tick();
        check("glitch valid", n_vrise - b_vrise, 0);
        check("glitch errors", (n_fe - b_fe) + (n_ov - b_ov), 0);
        expect_byte("after glitch 55", 8'h55);

        // Framing error, then line held low.
        b_vrise = n_vrise; b_fe = n_fe; b_ov = n_ov;
        ready = 1'b1;
        t0 = cyc;
        send_frame(8'hA5, 1'b0);
        check("frame_err pulses", n_fe - b_fe, 1);
        check("frame_err timing ok", int'((t_fe - t0) >= LAT_LO && (t_fe - t0) <= LAT_HI), 1);
        check("frame_err no valid", n_vrise - b_vrise, 0);
        rx = 1'b0;
        repeat (40) tick();
        check("held low quiet", (n_fe - b_fe) + (n_vrise - b_vrise) + (n_ov - b_ov), 1);
        rx = 1'b1;
        repeat (CPB) tick();
        check("line high quiet", (n_fe - b_fe) + (n_vrise - b_vrise) + (n_ov - b_ov), 1);
        expect_byte("after frame_err 3C", 8'h3C);

        // Overrun with consumer stalled.
        b_acc = n_acc; b_ov = n_ov;
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        check("ovr first valid", int'(valid), 1);
        check("ovr first data", int'(data), 'h11);
        check("ovr first no pulse", n_ov - b_ov, 0);
        send_frame(8'h22, 1'b1);
        check("ovr pulse count", n_ov - b_ov, 1);
        check("ovr held valid", int'(valid), 1);
        check("ovr held data", int'(data), 'h11);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("ovr consumed valid", int'(valid), 0);
        check("ovr consumed data", int'(data), 'h11);
        check("ovr accepts", n_acc - b_acc, 1);
        repeat (CPB) tick();

        // Reset in the middle of bit 3 of 0xF0 while a byte is held.
        ready = 1'b0;
        send_frame(8'h7E, 1'b1);
        check("pre-reset valid", int'(valid), 1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        rx = 1'b0;
        repeat (HB) tick();
        reset = 1'b0;
        #2;
        check("mid reset data", int'(data), 0);
        check("mid reset valid", int'(valid), 0);
        check("mid reset errors", int'(frame_err) + int'(overrun), 0);
        repeat (3) tick();
        b_vrise = n_vrise; b_fe = n_fe; b_ov = n_ov;
        reset = 1'b1;
        repeat (3) tick();
        rx = 1'b1;
        repeat (2 * CPB) tick();
        check("post reset quiet", (n_vrise - b_vrise) + (n_fe - b_fe) + (n_ov - b_ov), 0);
        expect_byte("after reset 81", 8'h81);

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
